// File: rtl/fetch_inst_buffer.sv
// Decoupling instruction buffer between IF2 predecode and decode.
// Two-wide push/pop circular queue with output gating and one-cycle flush.

module fetch_inst_buffer_lane #(
  parameter int W = 98
) (
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  // Invalid slots never expose stale storage.
  assign dout = vld ? din : '0;
endmodule

module fetch_inst_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       i_valid,
  input  logic [31:0]      i_inst0,
  input  logic [31:0]      i_inst1,
  input  logic [31:0]      i_pc0,
  input  logic [31:0]      i_pc1,
  input  logic [31:0]      i_pc_pre0,
  input  logic [31:0]      i_pc_pre1,
  input  logic [1:0]       i_type_predict0,
  input  logic [1:0]       i_type_predict1,
  output logic             o_ready,
  output logic [1:0]       o_valid,
  output logic [31:0]      o_inst0,
  output logic [31:0]      o_inst1,
  output logic [31:0]      o_pc0,
  output logic [31:0]      o_pc1,
  output logic [31:0]      o_pc_pre0,
  output logic [31:0]      o_pc_pre1,
  output logic [1:0]       o_type_predict0,
  output logic [1:0]       o_type_predict1,
  input  logic [1:0]       i_pop,
  output logic [PTR_W:0]   o_count
);
  localparam int NUM_LANES = 2;
  localparam int ENT_W     = 98;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_pre;
    logic [1:0]  type_predict;
  } entry_t;

  entry_t                               mem [DEPTH];
  logic [PTR_W-1:0]                     head, tail;
  logic [PTR_W:0]                       count;
  logic [NUM_LANES-1:0]                 push_lanes, pop_lanes;
  logic [1:0]                           n_push, n_pop;
  logic [NUM_LANES-1:0][PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [NUM_LANES-1:0][ENT_W-1:0]      in_ent, rd_ent, out_ent;
  entry_t                               out0, out1;

  assign o_ready = (count <= (PTR_W+1)'(DEPTH - 2));
  assign o_valid = (count >= (PTR_W+1)'(2)) ? 2'b11 :
                   (count == (PTR_W+1)'(1)) ? 2'b01 : 2'b00;
  assign o_count = count;

  // Slot-1-only encodings (10) are illegal and collapse to no-op.
  always_comb begin
    push_lanes = 2'b00;
    pop_lanes  = 2'b00;
    if (!flush) begin
      if (o_ready && (i_valid == 2'b11 || i_valid == 2'b01)) push_lanes = i_valid;
      if (i_pop == 2'b11 || i_pop == 2'b01) pop_lanes = i_pop & o_valid;
    end
  end

  assign n_push = {1'b0, push_lanes[0]} + {1'b0, push_lanes[1]};
  assign n_pop  = {1'b0, pop_lanes[0]}  + {1'b0, pop_lanes[1]};

  assign in_ent[0] = {i_inst0, i_pc0, i_pc_pre0, i_type_predict0};
  assign in_ent[1] = {i_inst1, i_pc1, i_pc_pre1, i_type_predict1};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign wr_ptr[k] = tail + PTR_W'(k);
    assign rd_ptr[k] = head + PTR_W'(k);
    assign rd_ent[k] = mem[rd_ptr[k]];
    fetch_inst_buffer_lane #(.W(ENT_W)) u_lane (
      .vld  (o_valid[k]),
      .din  (rd_ent[k]),
      .dout (out_ent[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (push_lanes[k]) mem[wr_ptr[k]] <= entry_t'(in_ent[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);
    end
  end

  assign out0 = entry_t'(out_ent[0]);
  assign out1 = entry_t'(out_ent[1]);

  assign o_inst0         = out0.inst;
  assign o_pc0           = out0.pc;
  assign o_pc_pre0       = out0.pc_pre;
  assign o_type_predict0 = out0.type_predict;
  assign o_inst1         = out1.inst;
  assign o_pc1           = out1.pc;
  assign o_pc_pre1       = out1.pc_pre;
  assign o_type_predict1 = out1.type_predict;
endmodule

// File: doc/fetch_inst_buffer.md
# fetch_inst_buffer

Instruction buffer between the second fetch stage (IF2, predecode) and the decoder that builds the `PC_set` record. Accepts up to two fetched instructions per cycle, with their PC, predicted next PC and predecode branch type. Presents up to two oldest entries per cycle to the decoder, in program order. Decouples fetch stalls from decode/issue back-pressure and is cleared in one cycle on pipeline flush.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 4.
- `PTR_W`, $clog2(DEPTH), pointer width (derived; do not override).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  pipeline flush (mispredict/exception); discards all entries.
- `i_valid`  in  2  IF2 slot valids. Slot 0 is older. Legal values: 00, 01, 11.
- `i_inst0`, `i_inst1`  in  32  instruction words.
- `i_pc0`, `i_pc1`  in  32  instruction PCs.
- `i_pc_pre0`, `i_pc_pre1`  in  32  predicted next PC (feeds `PC_pre`).
- `i_type_predict0`, `i_type_predict1`  in  2  predecode branch class (feeds `type_predict`).
- `o_ready`  out  1  buffer accepts a push this cycle.
- `o_valid`  out  2  head entries available. Values: 00, 01, 11.
- `o_inst0/1`, `o_pc0/1`, `o_pc_pre0/1`, `o_type_predict0/1`  out  32/32/32/2  head (slot 0) and head+1 (slot 1) entry fields.
- `i_pop`  in  2  decoder consumes slots. Legal values: 00, 01, 11.
- `o_count`  out  PTR_W+1  current occupancy.

## Operation
- Circular storage of DEPTH entries: {inst, pc, pc_pre, type_predict}, 98 bits each.
- State:
  - `head` and `tail` are PTR_W-bit pointers that wrap modulo DEPTH.
  - `count` is PTR_W+1 bits, range 0..DEPTH.
- Push:
  - Occurs when `o_ready` && `i_valid` != 00 && !`flush`.
  - n_push = 1 for 01, 2 for 11. i_valid = 10 is illegal and is treated as 00 (no push).
  - Slot 0 is written at `tail` and slot 1 at `tail+1` (mod DEPTH). `tail` then advances by n_push.
- Pop:
  - n_pop = popcount(i_pop & o_valid); i_pop = 10 is treated as 00.
  - `head` advances by n_pop. Popping more than is valid is masked off, never underflows.
- Occupancy: `count` <= count + n_push − n_pop. A simultaneous push and pop in the same cycle is legal.
- `o_ready` = (DEPTH − count ≥ 2), computed from the registered count only. A same-cycle pop does not raise it.
- `o_valid`: 11 if count ≥ 2, 01 if count == 1, 00 if count == 0.
- Outputs:
  - Slot 0 shows storage[head]; slot 1 shows storage[head+1 mod DEPTH].
  - Each slot's data fields are forced to 0 whenever its `o_valid` bit is 0.
- Flush:
  - Next edge sets head = tail = count = 0.
  - Same-cycle push and pop are ignored.
  - Storage contents are not cleared; they are unobservable because of output gating.
- Reset: head = tail = count = 0, and all storage is cleared to 0.
  - Output values: `o_valid` = 00, `o_ready` = 1, `o_count` = 0, all data outputs 0.
  - Reset mid-operation discards everything immediately (asynchronous).
- Order: entries leave in exactly the order written, slot 0 before slot 1. Wrap-around of either pointer is invisible at the ports.

## Timing
- Push-to-visible latency is 1 cycle: an entry written at edge N appears on `o_valid` in cycle N+1. There is no bypass when empty.
- Pop takes effect at the edge. The next entries are presented in the following cycle.
- `o_ready`, `o_valid` and `o_count` are pure functions of registered state. There is no combinational path from `i_valid`/`i_pop` to any output.
- Sustained throughput is 2 instr/cycle in and out when count is held between 2 and DEPTH−2.
- Flush asserted in cycle N: from cycle N+1, `o_valid` = 00, `o_ready` = 1 and `o_count` = 0. A push in cycle N+1 is accepted normally.
- Full boundary:
  - count = DEPTH−1 gives `o_ready` = 0, even when only one slot is offered.
  - count = DEPTH gives `o_ready` = 0.

## Test plan
- Reset then idle: assert `rst` mid-cycle → `o_valid` = 00, `o_ready` = 1, `o_count` = 0 immediately. All data outputs stay 0 for 5 cycles with no pushes.
- Single push then pop: push 01 with inst = 0x02800421, pc = 0x1C000000 → next cycle `o_valid` = 01, `o_inst0` = 0x02800421, `o_inst1` = 0. Then pop 01 → `o_valid` = 00 the cycle after.
- Fill with no pops (DEPTH = 8): push 11 four times with pcs 0x1C000000.. step 4 → `o_count` = 8 and `o_ready` = 0. A further push of 11 is ignored and count stays 8. Then pop 11 ×4 → pcs come out in order 0x1C000000..0x1C00001C.
- Wrap-around with concurrent traffic:
  - Setup: prefill 6, then for 20 cycles push 11 and pop 11 together.
  - Expected: count stays 6, PCs are strictly sequential across the pointer wrap, and there are no drops or duplicates.
- Flush with simultaneous push and pop:
  - Setup: count = 5; in one cycle assert `flush`, `i_valid` = 11 and `i_pop` = 11.
  - Expected: next cycle count = 0 and `o_valid` = 00. A push of 01 (pc = 0x1C000100) the cycle after appears alone at `o_pc0`.
- Illegal encodings: `i_valid` = 10 and `i_pop` = 10 for one cycle at count = 3 → count stays 3 and head/tail are unchanged. `i_pop` = 11 at count = 1 → only 1 is popped and count = 0.
